// File: rtl/sap_out_display_if.sv
// Front-panel output bus: SAP bus clock, output-register strobe, mode,
// monitored address/data buses, and the display outputs.
interface sap_out_display_if;
    logic       CLK;
    logic       nLO;
    logic       run;
    logic [3:0] ABUS;
    logic [7:0] DBUS;
    logic [7:0] outreg;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output CLK, nLO, run, ABUS, DBUS,
        input  outreg, seg, dp, an
    );

    modport slave (
        input  CLK, nLO, run, ABUS, DBUS,
        output outreg, seg, dp, an
    );
endinterface

// File: rtl/sap_out_display.sv
// SAP-1 output register with a 4-digit multiplexed 7-segment display.
// Program mode (run=1) shows outreg in decimal through a sequential
// double-dabble converter; monitor mode (run=0) shows ABUS and DBUS in hex.
// Optional build macro SAP_OUT_SIGNED_EN: treat outreg as two's complement
// in program mode and show a minus sign on the leftmost digit.
module sap_out_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic CLR,
    sap_out_display_if.slave bus
);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    conv_state_t state_q, state_d;

    logic             clk_prev;
    logic             bus_rise;
    logic [7:0]       outreg_q;
    logic [7:0]       conv_src;
    logic [7:0]       conv_in;
    logic [19:0]      shift_q;
    logic [2:0]       iter_q;
    logic [11:0]      bcd;
    logic             conv_start;
    logic             conv_step;
    logic             conv_done;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic             wrap;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [3:0]       an_q;
`ifdef SAP_OUT_SIGNED_EN
    logic             conv_sign;
    logic             disp_sign;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // One double-dabble iteration: correct each BCD nibble, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int k = 0; k < 3; k++) begin
            if (t[8+4*k +: 4] >= 4'd5)
                t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    assign bus_rise = bus.CLK & ~clk_prev;

`ifdef SAP_OUT_SIGNED_EN
    // -128 negates to 8'h80, which reads correctly as an unsigned magnitude.
    assign conv_in = outreg_q[7] ? (~outreg_q + 8'd1) : outreg_q;
`else
    assign conv_in = outreg_q;
`endif

    // Bus-clock edge detect and output-register load (program mode only).
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            clk_prev <= 1'b0;
            outreg_q <= 8'd0;
        end else begin
            clk_prev <= bus.CLK;
            if (bus_rise && !bus.nLO && bus.run)
                outreg_q <= bus.DBUS;
        end
    end

    // Converter state register.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Converter next state; a running conversion always finishes.
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        conv_step  = 1'b0;
        conv_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (outreg_q != conv_src) begin
                    conv_start = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                conv_step = 1'b1;
                if (iter_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                conv_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Converter datapath: load, shift, publish result.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            conv_src  <= 8'd0;
            shift_q   <= 20'd0;
            iter_q    <= 3'd0;
            bcd       <= 12'd0;
`ifdef SAP_OUT_SIGNED_EN
            conv_sign <= 1'b0;
            disp_sign <= 1'b0;
`endif
        end else if (conv_start) begin
            conv_src  <= outreg_q;
            shift_q   <= {12'd0, conv_in};
            iter_q    <= 3'd0;
`ifdef SAP_OUT_SIGNED_EN
            conv_sign <= outreg_q[7];
`endif
        end else if (conv_step) begin
            shift_q <= dd_step(shift_q);
            iter_q  <= iter_q + 3'd1;
        end else if (conv_done) begin
            bcd       <= shift_q[19:8];
`ifdef SAP_OUT_SIGNED_EN
            disp_sign <= conv_sign;
`endif
        end
    end

    assign wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    // Digit content for the current scan index, from the selected mode.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (bus.run) begin
            case (idx_q)
                2'd0: seg_d = hex7(bcd[3:0]);
                2'd1: seg_d = (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? SEG_BLANK : hex7(bcd[7:4]);
                2'd2: seg_d = (bcd[11:8] == 4'd0) ? SEG_BLANK : hex7(bcd[11:8]);
`ifdef SAP_OUT_SIGNED_EN
                default: seg_d = disp_sign ? SEG_MINUS : SEG_BLANK;
`else
                default: seg_d = SEG_BLANK;
`endif
            endcase
        end else begin
            case (idx_q)
                2'd0: seg_d = hex7(bus.DBUS[3:0]);
                2'd1: seg_d = hex7(bus.DBUS[7:4]);
                2'd2: seg_d = SEG_BLANK;
                default: begin
                    seg_d = hex7(bus.ABUS);
                    dp_d  = 1'b0;
                end
            endcase
        end
    end

    // Refresh timer; on wrap the current digit is latched and the index advances.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else if (wrap) begin
            cnt_q <= '0;
            idx_q <= idx_q + 2'd1;
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.outreg = outreg_q;
    assign bus.seg    = seg_q;
    assign bus.dp     = dp_q;
    assign bus.an     = an_q;
endmodule

// File: tb/tb_sap_out_display.sv
// Directed bench for sap_out_display with a 4-cycle digit refresh.
module tb_sap_out_display;
    logic clk;
    logic CLR;
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] fseg [4];
    logic [3:0] fdp;
    logic [3:0] seen;

    sap_out_display_if bus ();

    sap_out_display #(.REFRESH_DIV(4), .CNT_W(4)) dut (
        .clk (clk),
        .CLR (CLR),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample the scan for ncyc cycles, keeping the latest segments of each digit.
    task automatic capture(input int ncyc);
        seen = 4'b0000;
        repeat (ncyc) begin
            @(posedge clk); #1;
            case (bus.an)
                4'b1110: begin fseg[0] = bus.seg; fdp[0] = bus.dp; seen[0] = 1'b1; end
                4'b1101: begin fseg[1] = bus.seg; fdp[1] = bus.dp; seen[1] = 1'b1; end
                4'b1011: begin fseg[2] = bus.seg; fdp[2] = bus.dp; seen[2] = 1'b1; end
                4'b0111: begin fseg[3] = bus.seg; fdp[3] = bus.dp; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        check("scan_all_digits_seen", seen, 4'hF);
    endtask

    task automatic check_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dps);
        capture(24);
        check({tag, "_d3"}, fseg[3], s3);
        check({tag, "_d2"}, fseg[2], s2);
        check({tag, "_d1"}, fseg[1], s1);
        check({tag, "_d0"}, fseg[0], s0);
        check({tag, "_dp"}, fdp, dps);
    endtask

    // CLK pulse with nLO low; checks outreg on the edge cycle, returns at the following negedge.
    task automatic pulse_load(input logic [7:0] v, input logic [7:0] exp);
        @(negedge clk);
        bus.DBUS = v;
        bus.CLK  = 1'b1;
        bus.nLO  = 1'b0;
        @(posedge clk); #1;
        check("outreg_on_edge", bus.outreg, exp);
        @(negedge clk);
        bus.CLK = 1'b0;
        bus.nLO = 1'b1;
    endtask

    initial begin
        CLR      = 1'b1;
        bus.CLK  = 1'b0;
        bus.nLO  = 1'b1;
        bus.run  = 1'b1;
        bus.ABUS = 4'h0;
        bus.DBUS = 8'h00;
        for (int i = 0; i < 4; i++) fseg[i] = 7'h00;
        fdp = 4'h0;
        #2;
        check("reset_an", bus.an, 4'b1111);
        check("reset_seg", bus.seg, 7'h7F);
        check("reset_dp", bus.dp, 1'b1);
        check("reset_outreg", bus.outreg, 8'd0);
        check("reset_bcd", dut.bcd, 12'h000);
        repeat (2) @(negedge clk);
        CLR = 1'b0;

        repeat (3) @(posedge clk);
        #1 check("pre_wrap_an", bus.an, 4'b1111);
        @(posedge clk);
        #1 check("first_wrap_an", bus.an, 4'b1110);
        check("first_wrap_seg", bus.seg, 7'h40);
        check_frame("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'hF);

        // 173: latency of exactly 10 cycles from the load edge.
        pulse_load(8'd173, 8'd173);
        repeat (9) @(posedge clk);
        #1 check("bcd173_not_yet", dut.bcd, 12'h000);
        @(posedge clk);
        #1 check("bcd173", dut.bcd, 12'h173);
        check_frame("d173", 7'h7F, 7'h79, 7'h78, 7'h30, 4'hF);

        // nLO high: CLK edge does not load.
        @(negedge clk);
        bus.DBUS = 8'h55;
        bus.CLK  = 1'b1;
        @(negedge clk);
        bus.CLK  = 1'b0;
        @(posedge clk);
        #1 check("nlo_high_no_load", bus.outreg, 8'd173);

        // 5, then 200 four cycles into the conversion.
        pulse_load(8'd5, 8'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.DBUS = 8'd200;
        bus.CLK  = 1'b1;
        bus.nLO  = 1'b0;
        @(posedge clk);
        #1 check("outreg_200_midconv", bus.outreg, 8'd200);
        @(negedge clk);
        bus.CLK = 1'b0;
        bus.nLO = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("bcd_before_005", dut.bcd, 12'h173);
        @(posedge clk);
        #1 check("bcd_005", dut.bcd, 12'h005);
        repeat (8) @(posedge clk);
        @(posedge clk);
        #1 check("bcd_still_005", dut.bcd, 12'h005);
        @(posedge clk);
        #1 check("bcd_200", dut.bcd, 12'h200);
        check_frame("d200", 7'h7F, 7'h24, 7'h40, 7'h40, 4'hF);

        // Monitor mode.
        @(negedge clk);
        bus.run  = 1'b0;
        bus.ABUS = 4'hA;
        bus.DBUS = 8'h3C;
        check_frame("monitor", 7'h08, 7'h7F, 7'h30, 7'h46, 4'b0111);
        @(negedge clk);
        bus.CLK = 1'b1;
        bus.nLO = 1'b0;
        @(negedge clk);
        bus.CLK = 1'b0;
        bus.nLO = 1'b1;
        @(posedge clk);
        #1 check("monitor_no_load", bus.outreg, 8'd200);
        check("monitor_bcd_kept", dut.bcd, 12'h200);

        // CLR during SHIFT.
        @(negedge clk);
        bus.run = 1'b1;
        pulse_load(8'd99, 8'd99);
        repeat (3) @(posedge clk);
        #1 check("in_shift", dut.state_q, 2'd1);
        @(negedge clk);
        #2 CLR = 1'b1;
        #1;
        check("clr_outreg", bus.outreg, 8'd0);
        check("clr_state", dut.state_q, 2'd0);
        check("clr_an", bus.an, 4'b1111);
        check("clr_seg", bus.seg, 7'h7F);
        check("clr_bcd", dut.bcd, 12'h000);
        @(negedge clk);
        CLR = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("post_clr_pre_wrap", bus.an, 4'b1111);
        @(posedge clk);
        #1 check("post_clr_an", bus.an, 4'b1110);
        check("post_clr_seg", bus.seg, 7'h40);

        // 8'hF6: -10 when signed, 246 otherwise.
        pulse_load(8'hF6, 8'hF6);
        repeat (10) @(posedge clk);
`ifdef SAP_OUT_SIGNED_EN
        #1 check("bcd_f6", dut.bcd, 12'h010);
        check_frame("f6", 7'h3F, 7'h7F, 7'h79, 7'h40, 4'hF);
`else
        #1 check("bcd_f6", dut.bcd, 12'h246);
        check_frame("f6", 7'h7F, 7'h24, 7'h19, 7'h02, 4'hF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
